// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the panel button debouncer.
//   debounce_state_t : per-channel debounce FSM state (2-bit encoding)
//   calc_max_count   : number of clock cycles that make up one debounce interval
package debounce_pkg;

  typedef enum logic [1:0] {
    Released       = 2'd0,
    PressPending   = 2'd1,
    Held           = 2'd2,
    ReleasePending = 2'd3
  } debounce_state_t;

  function automatic int calc_max_count(input int period_ns, input int interval_ns);
    return interval_ns / period_ns;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the panel pins and the debouncer.
//   iUp/iDown/iSign : raw active-low button lines (asynchronous, bouncing)
//   oUp/oDown/oSign : debounced active-low levels, idle high
//   oAny            : active-high, set while any debounced output is low
// master = panel/stimulus side, slave = debouncer side.
interface button_debouncer_if;
  logic iUp;
  logic iDown;
  logic iSign;
  logic oUp;
  logic oDown;
  logic oSign;
  logic oAny;

  modport master (
    output iUp, iDown, iSign,
    input  oUp, oDown, oSign, oAny
  );

  modport slave (
    input  iUp, iDown, iSign,
    output oUp, oDown, oSign, oAny
  );
endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter and FSM.
//   clk_i     : system clock, rising edge
//   rst_i     : asynchronous active-high reset
//   raw_n_i   : raw active-low button line
//   clean_n_o : debounced active-low level, registered
//
// state          | meaning
// Released       | output high, synchronised input high
// PressPending   | input seen low, counting stable-low cycles
// Held           | output low, synchronised input low
// ReleasePending | input seen high, counting stable-high cycles
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int MaxCount = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_n_i,
  output logic clean_n_o
);

  localparam int CntW = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(MaxCount - 1);

  generate
    if (MaxCount < 2) begin : g_bad_max_count
      $fatal(1, "debounce_channel: MaxCount must be at least 2");
    end
  endgenerate

  logic            sync1_q;
  logic            sync2_q;
  debounce_state_t state_q;
  logic [CntW-1:0] cnt_q;
  logic            out_q;
  logic            cnt_last;

  assign cnt_last  = (cnt_q == LastCount);
  assign clean_n_o = out_q;

  // Idle-high reset value keeps a held button from looking like a press
  // until it has crossed both flops after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
    end
  end

  // The input check comes before the terminal-count check, so a bounce on
  // the very cycle the count completes still aborts the change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Released;
      cnt_q   <= '0;
      out_q   <= 1'b1;
    end else begin
      case (state_q)
        Released: begin
          if (!sync2_q) begin
            state_q <= PressPending;
            cnt_q   <= '0;
          end
        end
        PressPending: begin
          if (sync2_q) begin
            state_q <= Released;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q <= Held;
            out_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        Held: begin
          if (sync2_q) begin
            state_q <= ReleasePending;
            cnt_q   <= '0;
          end
        end
        ReleasePending: begin
          if (!sync2_q) begin
            state_q <= Held;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q <= Released;
            out_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= Released;
          cnt_q   <= '0;
          out_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces the three panel buttons (Up, Down, Sign) ahead of the pulse /
// auto-repeat generator and flags when any of them is held.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : button bundle (raw inputs in, debounced outputs and oAny out)
// Parameters: ClockPeriod_ns, DebounceInterval_ns (stability time required).
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int ClockPeriod_ns      = 20,
  parameter int DebounceInterval_ns = 10_000_000
) (
  input  logic                Clock,
  input  logic                Reset,
  button_debouncer_if.slave   bus
);

  localparam int MaxCount = calc_max_count(ClockPeriod_ns, DebounceInterval_ns);

  logic up_n;
  logic down_n;
  logic sign_n;

  debounce_channel #(.MaxCount(MaxCount)) u_up (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .raw_n_i   (bus.iUp),
    .clean_n_o (up_n)
  );

  debounce_channel #(.MaxCount(MaxCount)) u_down (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .raw_n_i   (bus.iDown),
    .clean_n_o (down_n)
  );

  debounce_channel #(.MaxCount(MaxCount)) u_sign (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .raw_n_i   (bus.iSign),
    .clean_n_o (sign_n)
  );

  assign bus.oUp   = up_n;
  assign bus.oDown = down_n;
  assign bus.oSign = sign_n;
  // Built only from registered outputs, so it cannot glitch.
  assign bus.oAny  = ~(up_n & down_n & sign_n);

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with ClockPeriod_ns=20, DebounceInterval_ns=200.
// Reference model: an output takes level v once the synchronised input (raw
// input delayed by two edges) has read v on MaxCount+1 consecutive edges.
module tb_button_debouncer;

  localparam int MC  = 10;
  localparam int HW  = MC + 3;  // raw history: 2 sync stages + MC+1 window

  logic Clock;
  logic Reset;
  button_debouncer_if bus ();

  button_debouncer #(
    .ClockPeriod_ns      (20),
    .DebounceInterval_ns (200)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {oAny, oSign, oDown, oUp}
  logic [3:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [HW-1:0] hist[3];
  logic [2:0]    mout;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) hist[c] = '1;
    mout = 3'b111;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clock);
      if (Reset) begin
        model_reset();
      end else begin
        logic [2:0] raw;
        raw = {bus.iSign, bus.iDown, bus.iUp};
        for (int c = 0; c < 3; c++) begin
          hist[c] = {hist[c][HW-2:0], raw[c]};
          if (hist[c][HW-1:2] == {(MC+1){~mout[c]}}) mout[c] = ~mout[c];
        end
      end
      #4;
      if (Reset) model_reset();  // asynchronous assertion between edges
      exp_q.push_back({~&mout, mout});
    end
  end

  // ---------------- monitor ----------------
  task automatic check_bit(input string name, input logic act, input logic expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check_bit("oUp",   bus.oUp,   e[0]);
        check_bit("oDown", bus.oDown, e[1]);
        check_bit("oSign", bus.oSign, e[2]);
        check_bit("oAny",  bus.oAny,  e[3]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_in(input logic [2:0] v);  // {Sign, Down, Up}
    bus.iUp   = v[0];
    bus.iDown = v[1];
    bus.iSign = v[2];
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    n_checks++;
    summary();
    $finish;
  end

  initial begin
    int n;
    int rem[3];
    logic [2:0] lvl;

    Reset = 1'b1;
    set_in(3'b111);
    hold(3);
    Reset = 1'b0;
    hold(4);

    // 1: clean press on Up with explicit latency measurement
    bus.iUp = 1'b0;
    n = 0;
    while (bus.oUp !== 1'b0 && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    // n counts the first sampling edge as 1
    n_checks++;
    if (n - 1 == MC + 2) n_pass++;
    else $display("FAIL press_latency: got %0d edges expected %0d", n - 1, MC + 2);
    hold(5);
    bus.iUp = 1'b1;
    hold(20);

    // 2: bouncing Down, then held
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) bus.iDown = ~bus.iDown;
      tick();
    end
    bus.iDown = 1'b0;
    hold(20);
    bus.iDown = 1'b1;
    hold(20);

    // 3: Sign held, short release glitch, then real release
    bus.iSign = 1'b0;
    hold(20);
    bus.iSign = 1'b1;
    hold(8);
    bus.iSign = 1'b0;
    hold(15);
    bus.iSign = 1'b1;
    hold(20);

    // 4: simultaneous Up/Down press, Up released alone
    set_in(3'b100);
    hold(20);
    bus.iUp = 1'b1;
    hold(20);
    bus.iDown = 1'b1;
    hold(20);

    // 5: reset in the middle of a count
    bus.iUp = 1'b0;
    hold(6);
    Reset = 1'b1;
    hold(2);
    Reset = 1'b0;
    hold(20);
    bus.iUp = 1'b1;
    hold(20);

    // 6: reset value with all inputs pressed
    set_in(3'b000);
    hold(15);
    Reset = 1'b1;
    hold(3);
    Reset = 1'b0;
    hold(20);
    set_in(3'b111);
    hold(20);

    // random bouncing with occasional resets
    lvl = 3'b111;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12))
                                               : int'($urandom_range(8, 30));
        end
        rem[c]--;
      end
      set_in(lvl);
      if (!Reset && $urandom_range(0, 399) == 0) Reset = 1'b1;
      else if (Reset && $urandom_range(0, 1) == 0) Reset = 1'b0;
      tick();
    end
    Reset = 1'b0;
    set_in(3'b111);
    hold(20);

    n = 0;
    while (exp_q.size() > 1 && n < 10) begin
      tick();
      n++;
    end
    @(negedge Clock);
    #1;
    summary();
    $finish;
  end

endmodule
